// File: rtl/sparce_skip_ctrl.sv
// SparCE skip controller: qualifies SASA hits, waits for the SPRF sparsity verdict and
// issues a held redirect to fetch. Optional statistics counters under SPARCE_SKIP_STATS_EN.
module sparce_skip_ctrl #(
    parameter int unsigned SKIP_W   = 5,
    parameter int unsigned MIN_SKIP = 2,
    parameter int unsigned CHK_TMO  = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              if_valid,
    input  logic [31:0]       pc,
    input  logic              ctrl_flow_enable,
    input  logic              sasa_hit,
    input  logic [SKIP_W-1:0] sasa_insts,
    input  logic              sparse_vld,
    input  logic              rs_sparse,
    input  logic              flush,
    input  logic              skip_ack,
    output logic              skip_req,
    output logic [31:0]       sparce_target,
    output logic              skipping
`ifdef SPARCE_SKIP_STATS_EN
    ,
    output logic [31:0]       skip_cnt,
    output logic [31:0]       abort_cnt
`endif
);

    localparam int unsigned TMO_W = (CHK_TMO > 1) ? $clog2(CHK_TMO) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_SKIP  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       lpc_q, lpc_d;
    logic [SKIP_W-1:0] linsts_q, linsts_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              skip_req_q, skip_req_d;
    logic [31:0]       sparce_target_q, sparce_target_d;
    logic              skipping_q, skipping_d;

    logic cand_c;
    logic ld_cand_c;
    logic ld_target_c;
    logic skip_done_c;
    logic abort_c;

    assign cand_c = if_valid & ctrl_flow_enable & sasa_hit & ~flush
                  & (sasa_insts >= SKIP_W'(MIN_SKIP));

    // State register plus latched candidate data
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q         <= ST_IDLE;
            lpc_q           <= '0;
            linsts_q        <= '0;
            tmo_cnt_q       <= '0;
            skip_req_q      <= 1'b0;
            sparce_target_q <= '0;
            skipping_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            lpc_q           <= lpc_d;
            linsts_q        <= linsts_d;
            tmo_cnt_q       <= tmo_cnt_d;
            skip_req_q      <= skip_req_d;
            sparce_target_q <= sparce_target_d;
            skipping_q      <= skipping_d;
        end
    end

    // Next-state logic; CHECK exits are evaluated in strict priority order
    always_comb begin
        state_d     = state_q;
        ld_cand_c   = 1'b0;
        ld_target_c = 1'b0;
        skip_done_c = 1'b0;
        abort_c     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cand_c) begin
                    state_d   = ST_CHECK;
                    ld_cand_c = 1'b1;
                end
            end
            ST_CHECK: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    abort_c = 1'b1;
                end else if (if_valid && !ctrl_flow_enable) begin
                    state_d = ST_IDLE;
                    abort_c = 1'b1;
                end else if (sparse_vld && rs_sparse) begin
                    state_d     = ST_SKIP;
                    ld_target_c = 1'b1;
                end else if (sparse_vld) begin
                    state_d = ST_IDLE;
                end else if (tmo_cnt_q == TMO_W'(CHK_TMO - 1)) begin
                    state_d = ST_IDLE;
                    abort_c = 1'b1;
                end
            end
            ST_SKIP: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    abort_c = 1'b1;
                end else if (skip_ack) begin
                    state_d     = ST_IDLE;
                    skip_done_c = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs and datapath updates decoded from the next state
    always_comb begin
        lpc_d           = lpc_q;
        linsts_d        = linsts_q;
        tmo_cnt_d       = tmo_cnt_q;
        sparce_target_d = sparce_target_q;
        skip_req_d      = (state_d == ST_SKIP);
        skipping_d      = (state_d != ST_IDLE);
        if (ld_cand_c) begin
            lpc_d     = pc;
            linsts_d  = sasa_insts;
            tmo_cnt_d = '0;
        end else if (state_q == ST_CHECK && state_d == ST_CHECK) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
        if (ld_target_c) begin
            sparce_target_d = lpc_q + (32'(linsts_q) << 2);
        end
    end

    assign skip_req      = skip_req_q;
    assign sparce_target = sparce_target_q;
    assign skipping      = skipping_q;

`ifdef SPARCE_SKIP_STATS_EN
    logic [31:0] skip_cnt_q, skip_cnt_d;
    logic [31:0] abort_cnt_q, abort_cnt_d;

    // Saturating event counters
    always_comb begin
        skip_cnt_d  = skip_cnt_q;
        abort_cnt_d = abort_cnt_q;
        if (skip_done_c && skip_cnt_q != 32'hFFFF_FFFF) begin
            skip_cnt_d = skip_cnt_q + 32'd1;
        end
        if (abort_c && abort_cnt_q != 32'hFFFF_FFFF) begin
            abort_cnt_d = abort_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            skip_cnt_q  <= '0;
            abort_cnt_q <= '0;
        end else begin
            skip_cnt_q  <= skip_cnt_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    assign skip_cnt  = skip_cnt_q;
    assign abort_cnt = abort_cnt_q;
`else
    logic unused_stats_c;
    assign unused_stats_c = skip_done_c ^ abort_c;
`endif

endmodule

// File: tb/tb_sparce_skip_ctrl.sv
// Directed bench for sparce_skip_ctrl; counter checks active when SPARCE_SKIP_STATS_EN is defined.
module tb_sparce_skip_ctrl;

    logic        CLK;
    logic        nRST;
    logic        if_valid;
    logic [31:0] pc;
    logic        ctrl_flow_enable;
    logic        sasa_hit;
    logic [4:0]  sasa_insts;
    logic        sparse_vld;
    logic        rs_sparse;
    logic        flush;
    logic        skip_ack;
    logic        skip_req;
    logic [31:0] sparce_target;
    logic        skipping;
`ifdef SPARCE_SKIP_STATS_EN
    logic [31:0] skip_cnt;
    logic [31:0] abort_cnt;
`endif

    int n_chk;
    int n_fail;
    int exp_skip;
    int exp_abort;

    sparce_skip_ctrl dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .if_valid         (if_valid),
        .pc               (pc),
        .ctrl_flow_enable (ctrl_flow_enable),
        .sasa_hit         (sasa_hit),
        .sasa_insts       (sasa_insts),
        .sparse_vld       (sparse_vld),
        .rs_sparse        (rs_sparse),
        .flush            (flush),
        .skip_ack         (skip_ack),
        .skip_req         (skip_req),
        .sparce_target    (sparce_target),
        .skipping         (skipping)
`ifdef SPARCE_SKIP_STATS_EN
        ,
        .skip_cnt         (skip_cnt),
        .abort_cnt        (abort_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_cnt(input string tag);
`ifdef SPARCE_SKIP_STATS_EN
        check({tag, "_skip_cnt"}, skip_cnt, 32'(exp_skip));
        check({tag, "_abort_cnt"}, abort_cnt, 32'(exp_abort));
`endif
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_in();
        if_valid         = 1'b0;
        pc               = 32'h0;
        ctrl_flow_enable = 1'b1;
        sasa_hit         = 1'b0;
        sasa_insts       = 5'd0;
        sparse_vld       = 1'b0;
        rs_sparse        = 1'b0;
        flush            = 1'b0;
        skip_ack         = 1'b0;
    endtask

    // Present a candidate fetch for one cycle; returns in the first CHECK cycle
    task automatic cand(input logic [31:0] p, input logic [4:0] n, input logic cfe);
        idle_in();
        if_valid         = 1'b1;
        pc               = p;
        sasa_hit         = 1'b1;
        sasa_insts       = n;
        ctrl_flow_enable = cfe;
        tick();
        idle_in();
    endtask

    task automatic sparse(input logic rs);
        sparse_vld = 1'b1;
        rs_sparse  = rs;
        tick();
        idle_in();
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        exp_skip  = 0;
        exp_abort = 0;
        idle_in();
        nRST = 1'b0;
        tick();
        check("rst_skip_req", 32'(skip_req), 32'd0);
        check("rst_target", sparce_target, 32'h0);
        check("rst_skipping", 32'(skipping), 32'd0);
        check_cnt("rst");
        nRST = 1'b1;
        tick();

        // Basic skip: pc=0x100, 3 insts -> target 0x10C
        cand(32'h100, 5'd3, 1'b1);
        check("t1_n1_skipping", 32'(skipping), 32'd1);
        check("t1_n1_skip_req", 32'(skip_req), 32'd0);
        sparse(1'b1);
        check("t1_n2_skip_req", 32'(skip_req), 32'd1);
        check("t1_n2_target", sparce_target, 32'h10C);
        tick();
        check("t1_n3_skip_req", 32'(skip_req), 32'd1);
        check("t1_n3_target", sparce_target, 32'h10C);
        skip_ack = 1'b1;
        tick();
        skip_ack = 1'b0;
        exp_skip++;
        check("t1_n4_skip_req", 32'(skip_req), 32'd0);
        check("t1_n4_skipping", 32'(skipping), 32'd0);
        check_cnt("t1");

        // Not sparse -> back to IDLE, not an abort
        cand(32'h200, 5'd3, 1'b1);
        sparse(1'b0);
        check("t2_skip_req", 32'(skip_req), 32'd0);
        check("t2_skipping", 32'(skipping), 32'd0);
        check_cnt("t2");

        // Control flow during CHECK aborts
        cand(32'h300, 5'd5, 1'b1);
        if_valid         = 1'b1;
        ctrl_flow_enable = 1'b0;
        tick();
        idle_in();
        exp_abort++;
        check("t3_skip_req", 32'(skip_req), 32'd0);
        check("t3_skipping", 32'(skipping), 32'd0);
        check_cnt("t3");

        // Target wraps modulo 2^32
        cand(32'hFFFF_FFF8, 5'd4, 1'b1);
        sparse(1'b1);
        check("t4_skip_req", 32'(skip_req), 32'd1);
        check("t4_target", sparce_target, 32'h0000_0008);
        skip_ack = 1'b1;
        tick();
        idle_in();
        exp_skip++;
        check("t4_after_ack", 32'(skip_req), 32'd0);

        // Timeout after 4 CHECK cycles
        cand(32'h400, 5'd2, 1'b1);
        tick();
        tick();
        tick();
        check("t5_chk4_skipping", 32'(skipping), 32'd1);
        tick();
        exp_abort++;
        check("t5_tmo_skipping", 32'(skipping), 32'd0);
        check("t5_tmo_skip_req", 32'(skip_req), 32'd0);
        check_cnt("t5");

        // Non-candidates: insts below minimum, zero insts, hit on control-flow instr, flush
        cand(32'h500, 5'd1, 1'b1);
        check("t5_insts1", 32'(skipping), 32'd0);
        cand(32'h500, 5'd0, 1'b1);
        check("t5_insts0", 32'(skipping), 32'd0);
        cand(32'h500, 5'd8, 1'b0);
        check("t5_cfe0", 32'(skipping), 32'd0);
        if_valid   = 1'b1;
        sasa_hit   = 1'b1;
        sasa_insts = 5'd8;
        flush      = 1'b1;
        tick();
        idle_in();
        check("t5_flush_cand", 32'(skipping), 32'd0);
        skip_ack = 1'b1;
        tick();
        idle_in();
        check("t5_ack_idle", 32'(skip_req), 32'd0);
        check_cnt("t5b");

        // Flush beats sparse verdict in CHECK
        cand(32'h600, 5'd3, 1'b1);
        flush = 1'b1;
        sparse(1'b1);
        exp_abort++;
        check("t6_flush_chk_req", 32'(skip_req), 32'd0);
        check("t6_flush_chk_skipping", 32'(skipping), 32'd0);

        // Flush and ack together in SKIP: dropped, not counted as skip
        cand(32'h700, 5'd6, 1'b1);
        sparse(1'b1);
        check("t6_skip_target", sparce_target, 32'h718);
        flush    = 1'b1;
        skip_ack = 1'b1;
        tick();
        idle_in();
        exp_abort++;
        check("t6_flush_ack_req", 32'(skip_req), 32'd0);
        check("t6_flush_ack_skipping", 32'(skipping), 32'd0);
        check_cnt("t6");

        // Async reset during SKIP clears request immediately
        cand(32'h800, 5'd3, 1'b1);
        sparse(1'b1);
        check("t7_pre_rst_req", 32'(skip_req), 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        exp_skip  = 0;
        exp_abort = 0;
        check("t7_rst_req", 32'(skip_req), 32'd0);
        check("t7_rst_target", sparce_target, 32'h0);
        check("t7_rst_skipping", 32'(skipping), 32'd0);
        check_cnt("t7");
        tick();
        nRST = 1'b1;
        tick();
        check("t7_post_rst_req", 32'(skip_req), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
